// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-side arbiter slice.
// Optional per-path beat statistics: define MEM_ARB_STATS_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam logic PATH1 = 1'b0;
    localparam logic PATH2 = 1'b1;

    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_AWIDTH    = 5;
    localparam int DEF_BURST_MAX = 10;

endpackage

// File: rtl/mem_arb_if.sv
// req/gnt/valid/data bundle between the two upstream paths and the arbiter.
// master = path side, slave = mem_arb_ctrl side.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
);

    logic              req1_i;
    logic              req2_i;
    logic              gnt1_o;
    logic              gnt2_o;
    logic              valid1_i;
    logic              valid2_i;
    logic [DWIDTH-1:0] data1_i;
    logic [DWIDTH-1:0] data2_i;

    modport master (
        output req1_i,
        output req2_i,
        output valid1_i,
        output valid2_i,
        output data1_i,
        output data2_i,
        input  gnt1_o,
        input  gnt2_o
    );

    modport slave (
        input  req1_i,
        input  req2_i,
        input  valid1_i,
        input  valid2_i,
        input  data1_i,
        input  data2_i,
        output gnt1_o,
        output gnt2_o
    );

endinterface

// File: rtl/mem_arb_ram.sv
// Write buffer: one write port, one registered read port.
// A read colliding with a write returns the old contents.
module mem_arb_ram
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Array has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin req/gnt arbiter for two paths feeding a sequential write buffer.
// Define MEM_ARB_STATS_EN to enable the per-path saturating beat counters.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arb_if.slave          bus,
    input  logic              clr_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [AWIDTH:0]   fill_o,
    output logic              full_o,
    output logic              err_o,
    output logic [15:0]       bcnt1_o,
    output logic [15:0]       bcnt2_o
);

    localparam int FW = AWIDTH + 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_GNT   = 2'(GNT);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          owner_q;
    logic          owner_d;
    logic          last_q;
    logic          last_d;
    logic [BW-1:0] beats_q;
    logic [BW-1:0] beats_d;
    logic [BW-1:0] beats_inc;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_inc;
    logic          err_q;
    logic          gnt1_q;
    logic          gnt2_q;

    logic              full;
    logic              active;
    logic              own_req;
    logic              own_valid;
    logic              oth_valid;
    logic [DWIDTH-1:0] own_data;
    logic              accept;
    logic              err_set;
    logic              winner;
    logic              any_req;

    assign full      = fill_q[AWIDTH];
    assign active    = (state_q == S_GNT) || (state_q == S_DRAIN);
    assign any_req   = bus.req1_i | bus.req2_i;

    always_comb begin
        own_req   = bus.req1_i;
        own_valid = bus.valid1_i;
        own_data  = bus.data1_i;
        oth_valid = bus.valid2_i;
        if (owner_q == PATH2) begin
            own_req   = bus.req2_i;
            own_valid = bus.valid2_i;
            own_data  = bus.data2_i;
            oth_valid = bus.valid1_i;
        end
    end

    assign accept  = active & own_valid & ~full & ~clr_i;
    assign err_set = active ? (oth_valid | (own_valid & full))
                            : (bus.valid1_i | bus.valid2_i);

    assign beats_inc = beats_q + BW'(accept);
    assign fill_inc  = fill_q + FW'(accept);

    // Contention goes to whichever path was not served last.
    always_comb begin
        winner = bus.req2_i ? PATH2 : PATH1;
        if (bus.req1_i && bus.req2_i) begin
            winner = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beats_d = beats_q;
        unique case (state_q)
            S_IDLE: begin
                if (!full && any_req) begin
                    state_d = S_GNT;
                    owner_d = winner;
                    beats_d = '0;
                end
            end
            S_GNT: begin
                beats_d = beats_inc;
                if (clr_i || !own_req ||
                    beats_inc == BW'(BURST_MAX) ||
                    fill_inc[AWIDTH]) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= PATH1;
            last_q  <= PATH2;
            beats_q <= '0;
            gnt1_q  <= 1'b0;
            gnt2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            gnt1_q  <= (state_d == S_GNT) && (owner_d == PATH1);
            gnt2_q  <= (state_d == S_GNT) && (owner_d == PATH2);
        end
    end

    // The pointer never wraps, so fill doubles as the write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            err_q  <= 1'b0;
        end else if (clr_i) begin
            fill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            fill_q <= fill_inc;
            err_q  <= err_q | err_set;
        end
    end

    mem_arb_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (accept),
        .waddr  (fill_q[AWIDTH-1:0]),
        .wdata  (own_data),
        .re     (rd_en_i),
        .raddr  (rd_addr_i),
        .rdata  (rd_data_o),
        .rvalid (rd_valid_o)
    );

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cnt1_q;
    logic [15:0] cnt2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else if (clr_i) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else if (accept) begin
            if (owner_q == PATH1 && cnt1_q != 16'hFFFF) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
            if (owner_q == PATH2 && cnt2_q != 16'hFFFF) begin
                cnt2_q <= cnt2_q + 16'd1;
            end
        end
    end

    assign bcnt1_o = cnt1_q;
    assign bcnt2_o = cnt2_q;
`else
    assign bcnt1_o = '0;
    assign bcnt2_o = '0;
`endif

    assign bus.gnt1_o = gnt1_q;
    assign bus.gnt2_o = gnt2_q;
    assign fill_o     = fill_q;
    assign full_o     = full;
    assign err_o      = err_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed and random checks of mem_arb_ctrl against a transaction-level model.
// Define MEM_ARB_STATS_EN to also check the beat counters.
module tb_mem_arb_ctrl;
    import mem_arb_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int BM    = 10;
    localparam int DEPTH = 32;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_DRAIN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_arb_if #(.DWIDTH(DW)) bus ();

    logic          clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   fill;
    logic          full;
    logic          err;
    logic [15:0]   bcnt1;
    logic [15:0]   bcnt2;

    mem_arb_ctrl #(
        .DWIDTH    (DW),
        .AWIDTH    (AW),
        .BURST_MAX (BM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_i      (clr),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .fill_o     (fill),
        .full_o     (full),
        .err_o      (err),
        .bcnt1_o    (bcnt1),
        .bcnt2_o    (bcnt2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase of the current grant, queue-like buffer.
    int          m_phase;
    int          m_owner;
    int          m_last;
    int          m_beats;
    int          m_fill;
    bit          m_err;
    bit          m_g1;
    bit          m_g2;
    int          m_c1;
    int          m_c2;
    logic [7:0]  m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  m_rdata;
    bit          m_rvalid;
    bit          m_rknown;

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_owner  = 0;
        m_last   = 2;
        m_beats  = 0;
        m_fill   = 0;
        m_err    = 0;
        m_g1     = 0;
        m_g2     = 0;
        m_c1     = 0;
        m_c2     = 0;
        m_rdata  = 8'h00;
        m_rvalid = 0;
        m_rknown = 1;
    endtask

    task automatic model_edge(input logic r1, input logic r2,
                              input logic v1, input logic v2,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic c, input logic re,
                              input logic [4:0] ra);
        bit         was_full;
        bit         serving;
        bit         e;
        int         take;
        logic [7:0] wd;
        was_full = (m_fill == DEPTH);
        serving  = (m_phase != PH_IDLE);
        e        = 0;
        take     = 0;
        wd       = 8'h00;
        if (v1) begin
            if (serving && m_owner == 1) begin
                if (was_full) e = 1;
                else if (!c) begin take = 1; wd = d1; end
            end else e = 1;
        end
        if (v2) begin
            if (serving && m_owner == 2) begin
                if (was_full) e = 1;
                else if (!c) begin take = 2; wd = d2; end
            end else e = 1;
        end
        m_rvalid = re;
        if (re) begin
            m_rdata  = m_mem[ra];
            m_rknown = m_known[ra];
        end
        if (take != 0) begin
            m_mem[m_fill]   = wd;
            m_known[m_fill] = 1;
            m_fill++;
            if (take == 1 && m_c1 < 65535) m_c1++;
            if (take == 2 && m_c2 < 65535) m_c2++;
        end
        case (m_phase)
            PH_IDLE: begin
                if (!was_full && (r1 || r2)) begin
                    if (r1 && r2) m_owner = (m_last == 1) ? 2 : 1;
                    else          m_owner = r1 ? 1 : 2;
                    m_phase = PH_SERVE;
                    m_beats = 0;
                end
            end
            PH_SERVE: begin
                if (take != 0) m_beats++;
                if (c || !(m_owner == 1 ? r1 : r2) ||
                    m_beats == BM || m_fill == DEPTH)
                    m_phase = PH_DRAIN;
            end
            default: begin
                m_phase = PH_IDLE;
                m_last  = m_owner;
            end
        endcase
        if (c) begin
            m_fill = 0;
            m_err  = 0;
            m_c1   = 0;
            m_c2   = 0;
        end else if (e) begin
            m_err = 1;
        end
        m_g1 = (m_phase == PH_SERVE) && (m_owner == 1);
        m_g2 = (m_phase == PH_SERVE) && (m_owner == 2);
    endtask

    task automatic compare_all();
        chk("gnt1", 32'(bus.gnt1_o), 32'(m_g1));
        chk("gnt2", 32'(bus.gnt2_o), 32'(m_g2));
        chk("onehot", 32'(bus.gnt1_o & bus.gnt2_o), 32'd0);
        chk("fill", 32'(fill), 32'(m_fill));
        chk("full", 32'(full), 32'(m_fill == DEPTH));
        chk("err", 32'(err), 32'(m_err));
        chk("rvalid", 32'(rd_valid), 32'(m_rvalid));
        if (m_rknown) chk("rdata", 32'(rd_data), 32'(m_rdata));
`ifdef MEM_ARB_STATS_EN
        chk("bcnt1", 32'(bcnt1), 32'(m_c1));
        chk("bcnt2", 32'(bcnt2), 32'(m_c2));
`else
        chk("bcnt1", 32'(bcnt1), 32'd0);
        chk("bcnt2", 32'(bcnt2), 32'd0);
`endif
    endtask

    task automatic step();
        logic       r1, r2, v1, v2, c, re;
        logic [7:0] d1, d2;
        logic [4:0] ra;
        r1 = bus.req1_i;   r2 = bus.req2_i;
        v1 = bus.valid1_i; v2 = bus.valid2_i;
        d1 = bus.data1_i;  d2 = bus.data2_i;
        c  = clr; re = rd_en; ra = rd_addr;
        @(posedge clk);
        model_edge(r1, r2, v1, v2, d1, d2, c, re, ra);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.req1_i   = 1'b0;
        bus.req2_i   = 1'b0;
        bus.valid1_i = 1'b0;
        bus.valid2_i = 1'b0;
        bus.data1_i  = 8'h00;
        bus.data2_i  = 8'h00;
        clr          = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_chk(input string tag, input int a,
                            input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = 5'(a);
        step();
        chk(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b0;
    endtask

    initial begin
        int n1, n2, gap, cyc, k;
        bit done;

        #2;
        do_reset();
        chk("rst_fill", 32'(fill), 32'd0);

        // Single requester, four late-valid beats.
        bus.req1_i = 1'b1;
        step();
        chk("s1_gnt_up", 32'(bus.gnt1_o), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            bus.valid1_i = 1'b1;
            bus.data1_i  = 8'(8'h11 + i);
            step();
        end
        bus.valid1_i = 1'b0;
        bus.req1_i   = 1'b0;
        step();
        chk("s1_gnt_dn", 32'(bus.gnt1_o), 32'd0);
        step();
        chk("s1_fill", 32'(fill), 32'd4);
        for (int i = 0; i < 4; i++) read_chk("s1_rd", i, 8'(8'h11 + i));
        step();
        chk("s1_rv_dn", 32'(rd_valid), 32'd0);

        // Both requesting, continuous streams.
        do_reset();
        bus.req1_i = 1'b1;
        bus.req2_i = 1'b1;
        n1 = 0; n2 = 0; gap = 0; cyc = 0; done = 0;
        while (!done && cyc < 80) begin
            bus.valid1_i = bus.gnt1_o;
            bus.valid2_i = bus.gnt2_o;
            bus.data1_i  = 8'(8'h40 + n1);
            bus.data2_i  = 8'(8'h80 + n2);
            if (bus.gnt1_o) n1++;
            if (bus.gnt2_o) n2++;
            if (n1 > 0 && n2 == 0 && !bus.gnt1_o && !bus.gnt2_o) gap++;
            if (n2 > 0 && !bus.gnt2_o) done = 1;
            else begin
                step();
                cyc++;
            end
        end
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_n1", 32'(n1), 32'd10);
        chk("s2_n2", 32'(n2), 32'd10);
        chk("s2_gap", 32'(gap), 32'd2);
        idle_inputs();
        step();
        step();
        chk("s2_fill", 32'(fill), 32'd20);
`ifdef MEM_ARB_STATS_EN
        chk("s2_bc1", 32'(bcnt1), 32'd10);
        chk("s2_bc2", 32'(bcnt2), 32'd10);
`else
        chk("s2_bc1", 32'(bcnt1), 32'd0);
        chk("s2_bc2", 32'(bcnt2), 32'd0);
`endif
        read_chk("s2_rd0", 0, 8'h40);
        read_chk("s2_rd10", 10, 8'h80);

        // Valid during DRAIN is kept, during IDLE is an error.
        do_reset();
        bus.req1_i = 1'b1;
        step();
        bus.req1_i = 1'b0;
        step();
        chk("s3_gnt", 32'(bus.gnt1_o), 32'd0);
        bus.valid1_i = 1'b1;
        bus.data1_i  = 8'h5A;
        step();
        chk("s3_fill", 32'(fill), 32'd1);
        chk("s3_err0", 32'(err), 32'd0);
        bus.data1_i = 8'h5B;
        step();
        chk("s3_err1", 32'(err), 32'd1);
        chk("s3_fill2", 32'(fill), 32'd1);
        bus.valid1_i = 1'b0;
        read_chk("s3_rd", 0, 8'h5A);

        // Overflow.
        do_reset();
        bus.req1_i = 1'b1;
        k = 0; cyc = 0;
        while (m_fill < DEPTH && cyc < 200) begin
            bus.valid1_i = bus.gnt1_o;
            bus.data1_i  = 8'(k + 1);
            if (bus.gnt1_o) k++;
            step();
            cyc++;
        end
        chk("s4_full", 32'(full), 32'd1);
        chk("s4_fill", 32'(fill), 32'd32);
        chk("s4_gnt", 32'(bus.gnt1_o), 32'd0);
        bus.valid1_i = 1'b1;
        bus.data1_i  = 8'hEE;
        step();
        bus.valid1_i = 1'b0;
        chk("s4_err", 32'(err), 32'd1);
        chk("s4_fill2", 32'(fill), 32'd32);
        step();
        chk("s4_nogrant", 32'(bus.gnt1_o), 32'd0);
        read_chk("s4_rd31", 31, 8'd32);

        // clr in the middle of a burst.
        do_reset();
        bus.req1_i = 1'b1;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 50) begin
            bus.valid1_i = bus.gnt1_o;
            bus.data1_i  = 8'(8'h30 + k);
            if (bus.gnt1_o) k++;
            step();
            cyc++;
        end
        clr          = 1'b1;
        bus.valid1_i = 1'b1;
        bus.data1_i  = 8'h99;
        step();
        clr = 1'b0;
        chk("s5_fill", 32'(fill), 32'd0);
        chk("s5_err", 32'(err), 32'd0);
        chk("s5_gnt", 32'(bus.gnt1_o), 32'd0);
        cyc = 0;
        while (m_fill < 1 && cyc < 20) begin
            bus.valid1_i = bus.gnt1_o;
            bus.data1_i  = 8'hC3;
            step();
            cyc++;
        end
        bus.req1_i   = 1'b0;
        bus.valid1_i = 1'b0;
        step();
        step();
        read_chk("s5_rd0", 0, 8'hC3);

        // Async reset while a grant is held.
        bus.req2_i = 1'b1;
        step();
        step();
        do_reset();
        chk("arst_gnt", 32'(bus.gnt2_o), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.req1_i   = ($urandom % 4) != 0;
            bus.req2_i   = ($urandom % 4) != 0;
            bus.valid1_i = bus.gnt1_o ? (($urandom % 8) != 0)
                                      : (($urandom % 24) == 0);
            bus.valid2_i = bus.gnt2_o ? (($urandom % 8) != 0)
                                      : (($urandom % 24) == 0);
            bus.data1_i  = 8'($urandom);
            bus.data2_i  = 8'($urandom);
            clr          = ($urandom % 64) == 0;
            rd_en        = ($urandom % 2) != 0;
            rd_addr      = 5'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
